// File: rtl/led_mode_ctrl_pkg.sv
// led_mode_ctrl_pkg: mode encodings, button roles and the chase rotate helper.
package led_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam int BTN_MODE_UP = 0;
    localparam int BTN_MODE_DN = 1;
    localparam int BTN_SPD_UP  = 2;
    localparam int BTN_SPD_DN  = 3;

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_db,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_db_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_db_d <= r_db;
            if (r_s2 == r_db)
                r_cnt <= '0;
            else if (32'(r_cnt) == DEBOUNCE_CYCLES - 1) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_db    = r_db;
    assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: button-driven mode/speed sequencer producing registered LED patterns from the switches.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_BASE       = 25_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       ck_rst,
    input  logic [3:0] sw,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [1:0] mode
);

    localparam int PW = $clog2(TICK_BASE + 1);

    logic [3:0]    r_sw1;
    logic [3:0]    r_sw2;
    mode_t         r_mode;
    logic [1:0]    r_speed;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_pos;
    logic [3:0]    r_count;
    logic          r_phase;
    logic [3:0]    r_led;

    logic [3:0]    w_db;
    logic [3:0]    w_press;
    logic          w_up;
    logic          w_dn;
    logic          w_mode_chg;
    mode_t         w_mode_nxt;
    logic [1:0]    w_spd_nxt;
    logic          w_spd_chg;
    logic          w_term;
    logic          w_step;
    logic [PW-1:0] w_presc_nxt;
    logic [3:0]    w_pos_nxt;
    logic [3:0]    w_count_nxt;
    logic          w_phase_nxt;
    logic [3:0]    w_led_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk   (CLK100MHZ),
            .i_rst_n (ck_rst),
            .i_btn   (btn[i]),
            .o_db    (w_db[i]),
            .o_press (w_press[i])
        );
    end

    assign w_up       = w_press[BTN_MODE_UP] & ~w_press[BTN_MODE_DN];
    assign w_dn       = w_press[BTN_MODE_DN] & ~w_press[BTN_MODE_UP];
    assign w_mode_chg = w_up | w_dn;
    assign w_mode_nxt = w_up ? mode_t'(r_mode + 2'd1) : w_dn ? mode_t'(r_mode - 2'd1) : r_mode;

    assign w_spd_nxt = (w_press[BTN_SPD_UP] & ~w_press[BTN_SPD_DN] & (r_speed != 2'd3)) ? r_speed + 2'd1 :
                       (w_press[BTN_SPD_DN] & ~w_press[BTN_SPD_UP] & (r_speed != 2'd0)) ? r_speed - 2'd1 :
                       r_speed;
    assign w_spd_chg = w_spd_nxt != r_speed;

    // A mode or speed reload swallows a coinciding terminal count.
    assign w_term      = 32'(r_presc) == (TICK_BASE >> r_speed) - 1;
    assign w_step      = w_term & ~w_mode_chg & ~w_spd_chg;
    assign w_presc_nxt = (w_mode_chg | w_spd_chg | w_term) ? '0 : r_presc + PW'(1);
    assign w_pos_nxt   = w_mode_chg ? 4'b0001 : w_step ? rotl4(r_pos) : r_pos;
    assign w_count_nxt = w_mode_chg ? 4'd0 : w_step ? r_count + 4'd1 : r_count;
    assign w_phase_nxt = w_mode_chg ? 1'b1 : w_step ? ~r_phase : r_phase;

    // Driven from next-state values so a new mode shows on led the same edge it is taken.
    assign w_led_nxt = (w_mode_nxt == MODE_STATIC) ? (r_sw2 | w_db) :
                       (w_mode_nxt == MODE_BLINK)  ? (w_phase_nxt ? r_sw2 : 4'd0) :
                       (w_mode_nxt == MODE_CHASE)  ? ((r_sw2 == 4'd0) ? w_pos_nxt : (w_pos_nxt & r_sw2)) :
                       w_count_nxt;

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_sw1   <= 4'd0;
            r_sw2   <= 4'd0;
            r_mode  <= MODE_STATIC;
            r_speed <= 2'd0;
            r_presc <= '0;
            r_pos   <= 4'b0001;
            r_count <= 4'd0;
            r_phase <= 1'b1;
            r_led   <= 4'd0;
        end else begin
            r_sw1   <= sw;
            r_sw2   <= r_sw1;
            r_mode  <= w_mode_nxt;
            r_speed <= w_spd_nxt;
            r_presc <= w_presc_nxt;
            r_pos   <= w_pos_nxt;
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign led  = r_led;
    assign mode = r_mode;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed sequences, press tables and random stimulus against a cycle reference model.
module tb_led_mode_ctrl;

    localparam int D  = 4;
    localparam int TB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'd0;
    logic [3:0] btn   = 4'd0;
    logic [3:0] led;
    logic [1:0] mode;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] b;
        int         m;
    } vec_t;

    int m_sw[2], m_btn[2], m_db[4], m_dbp[4], m_dbc[4];
    int m_mode, m_speed, m_presc, m_idx, m_cnt, m_phase, m_led;

    led_mode_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_BASE(TB)) dut (
        .CLK100MHZ (clk),
        .ck_rst    (rst_n),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_db[b]  = 0;
            m_dbp[b] = 0;
            m_dbc[b] = 0;
        end
        m_sw  = '{0, 0};
        m_btn = '{0, 0};
        m_mode = 0; m_speed = 0; m_presc = 0; m_idx = 0; m_cnt = 0; m_phase = 1; m_led = 0;
    endtask

    // Behaviour of one clock edge, computed from the values held before the edge.
    task automatic model_step();
        int ssw, sbtn, dbv, ns, bit_s, pos;
        bit pr[4];
        bit up, dn;
        ssw  = m_sw[1];
        sbtn = m_btn[1];
        dbv  = 0;
        for (int b = 0; b < 4; b++) begin
            pr[b] = (m_db[b] == 1) && (m_dbp[b] == 0);
            dbv  += m_db[b] << b;
        end
        up = pr[0] && !pr[1];
        dn = pr[1] && !pr[0];
        ns = (pr[2] && !pr[3]) ? ((m_speed < 3) ? m_speed + 1 : 3) :
             (pr[3] && !pr[2]) ? ((m_speed > 0) ? m_speed - 1 : 0) : m_speed;
        if (up || dn) begin
            m_mode  = (m_mode + (up ? 1 : 3)) % 4;
            m_presc = 0; m_idx = 0; m_cnt = 0; m_phase = 1;
        end else if (ns != m_speed)
            m_presc = 0;
        else if (m_presc == (TB >> m_speed) - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % 4;
            m_cnt   = (m_cnt + 1) % 16;
            m_phase = 1 - m_phase;
        end else
            m_presc++;
        m_speed = ns;
        pos = 1 << m_idx;
        case (m_mode)
            0: m_led = ssw | dbv;
            1: m_led = m_phase ? ssw : 0;
            2: m_led = (ssw == 0) ? pos : (pos & ssw);
            default: m_led = m_cnt;
        endcase
        for (int b = 0; b < 4; b++) begin
            m_dbp[b] = m_db[b];
            bit_s = (sbtn >> b) & 1;
            if (bit_s == m_db[b]) m_dbc[b] = 0;
            else if (m_dbc[b] == D - 1) begin
                m_db[b]  = bit_s;
                m_dbc[b] = 0;
            end else m_dbc[b]++;
        end
        m_sw[1]  = m_sw[0];
        m_sw[0]  = int'(sw);
        m_btn[1] = m_btn[0];
        m_btn[0] = int'(btn);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_led", 32'(led), 32'(m_led));
        check("model_mode", 32'(mode), 32'(m_mode));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] b, input int exp, input string nm);
        btn = b;
        ticks(8);
        btn = 4'd0;
        ticks(12);
        check(nm, 32'(mode), 32'(exp));
    endtask

    initial begin
        vec_t t_mode[2];
        vec_t t_spd[4];
        vec_t t_wrap[3];
        logic [3:0] v;
        logic [3:0] chase_exp[4];
        int n;
        t_mode    = '{'{4'b0001, 2}, '{4'b0001, 3}};
        t_spd     = '{'{4'b0100, 3}, '{4'b0100, 3}, '{4'b0100, 3}, '{4'b0100, 3}};
        t_wrap    = '{'{4'b0001, 0}, '{4'b0010, 3}, '{4'b0011, 3}};
        chase_exp = '{4'b0000, 4'b0100, 4'b0000, 4'b0001};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;

        // switch latency in STATIC
        sw = 4'b1010;
        ticks(2);
        check("sw_lat2", 32'(led), 32'd0);
        tick();
        check("sw_lat3", 32'(led), 32'b1010);

        // short bounce is ignored, then a held press moves to BLINK
        sw = 4'b0110;
        ticks(3);
        btn = 4'b0001;
        ticks(2);
        btn = 4'd0;
        ticks(12);
        check("bounce_mode", 32'(mode), 32'd0);
        check("bounce_led", 32'(led), 32'b0110);
        btn = 4'b0001;
        n = 0;
        while (mode != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        check("press_lat", 32'(n), 32'd7);
        check("blink_on", 32'(led), 32'b0110);
        ticks(3);
        btn = 4'd0;
        ticks(12);
        check("blink_15", 32'(led), 32'b0110);
        check("mode_once", 32'(mode), 32'd1);
        tick();
        check("blink_16", 32'(led), 32'd0);
        ticks(16);
        check("blink_32", 32'(led), 32'b0110);

        // COUNT at speed 0, then saturating speed-up
        foreach (t_mode[i]) press(t_mode[i].b, t_mode[i].m, "tbl_mode");
        sw = 4'd0;
        ticks(3);
        for (int i = 0; i < 3; i++) begin
            v = led;
            ticks(16);
            check("cnt_slow", 32'(led), 32'(4'(v + 4'd1)));
        end
        foreach (t_spd[i]) press(t_spd[i].b, t_spd[i].m, "tbl_spd");
        for (int i = 0; i < 8; i++) begin
            v = led;
            ticks(2);
            check("cnt_fast", 32'(led), 32'(4'(v + 4'd1)));
        end

        // wraps and simultaneous mode buttons
        foreach (t_wrap[i]) press(t_wrap[i].b, t_wrap[i].m, "tbl_wrap");

        // CHASE with and without a switch mask
        sw = 4'b0101;
        ticks(3);
        btn = 4'b0010;
        n = 0;
        while (mode != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        check("chase_enter", 32'(led), 32'b0001);
        foreach (chase_exp[i]) begin
            ticks(2);
            check("chase_mask", 32'(led), 32'(chase_exp[i]));
        end
        btn = 4'd0;
        sw  = 4'd0;
        ticks(12);
        for (int i = 0; i < 5; i++) begin
            v = led;
            ticks(2);
            check("chase_rot", 32'(led), 32'({v[2:0], v[3]}));
        end

        // asynchronous reset in COUNT at count 7
        press(4'b0001, 3, "to_count");
        n = 0;
        while (led != 4'd7 && n < 100) begin
            tick();
            n++;
        end
        check("cnt7_found", 32'(led), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'd0);
        check("async_mode", 32'(mode), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        press(4'b0010, 3, "post_rst_mode");
        v = led;
        ticks(16);
        check("post_rst_speed0", 32'(led), 32'(4'(v + 4'd1)));

        // random switches and buttons including bounces and simultaneous presses
        for (int i = 0; i < 200; i++) begin
            sw = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: btn = 4'd0;
                1: btn = 4'(1 << $urandom_range(0, 3));
                2: btn = 4'($urandom_range(0, 15));
                default: btn = btn;
            endcase
            ticks($urandom_range(1, 10));
        end
        btn = 4'd0;
        ticks(20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
